// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and types for the multi-port integer register file.
//   XLEN_DEFAULT      : data width of the default core
//   REG_COUNT_DEFAULT : architectural register count of the default core
//   reg_addr_t/xlen_t : address and data types for the default core
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_COUNT_DEFAULT = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundles the read, write and scoreboard signals of regfile_mp.
//   master : issue/writeback side (drives addresses, write data, scoreboard
//            controls; receives read data and busy status)
//   slave  : the register file itself
// Port i of a packed field occupies [i*AW +: AW] or [i*XLEN +: XLEN].
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int REG_COUNT = REG_COUNT_DEFAULT,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    localparam int AW       = $clog2(REG_COUNT)
);

    logic [NUM_READ*AW-1:0]    rd_addr;
    logic [NUM_READ*XLEN-1:0]  rd_data;
    logic [NUM_READ-1:0]       rd_busy;
    logic [NUM_WRITE-1:0]      wr_en;
    logic [NUM_WRITE*AW-1:0]   wr_addr;
    logic [NUM_WRITE*XLEN-1:0] wr_data;
    logic                      sb_set_en;
    logic [AW-1:0]             sb_set_addr;
    logic                      sb_flush;
    logic                      any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits for the issue stage.
//   clk, rst_n  : clock, asynchronous active-low reset (clears all bits)
//   wr_en/addr  : writeback ports; a write to a register clears its bit
//   sb_set_*    : marks a destination register pending
//   sb_flush    : clears every bit, overriding a same-cycle set
//   busy        : registered busy vector
//   any_busy    : OR of the busy vector
// Priority per bit: flush > set > clear > hold.
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEFAULT,
    parameter int NUM_WRITE = 1,
    parameter int ZERO_REG  = 1,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WRITE-1:0]    wr_en,
    input  logic [NUM_WRITE*AW-1:0] wr_addr,
    input  logic                    sb_set_en,
    input  logic [AW-1:0]           sb_set_addr,
    input  logic                    sb_flush,
    output logic [REG_COUNT-1:0]    busy,
    output logic                    any_busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Decoding against every valid index means out-of-range addresses simply
    // match nothing.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            // A new producer issued in the same cycle keeps the bit set.
            if (sb_set_en && (sb_set_addr == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                busy_d[r] = 1'b1;
            end
        end
        if (sb_flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file with busy scoreboard.
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset, clears data and busy bits
//   bus   : regfile_mp_if slave modport
//           rd_addr/rd_data/rd_busy : combinational read ports
//           wr_en/wr_addr/wr_data   : synchronous write ports
//           sb_set_en/addr, sb_flush: scoreboard controls
//           any_busy                : OR of all busy bits
// Writes to the same register from several ports resolve to the highest
// index port, both in the array and on the bypass path.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int REG_COUNT = REG_COUNT_DEFAULT,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_mp_if.slave    bus
);

    logic [XLEN-1:0]          regs_q [REG_COUNT];
    logic [XLEN-1:0]          regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]     busy;
    logic [NUM_WRITE-1:0]     wr_ok;
    logic [NUM_READ*XLEN-1:0] rd_data_c;
    logic [NUM_READ-1:0]      rd_busy_c;

    // True when the address names a writable register: in range and not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            if ((a == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    always_comb begin
        for (int j = 0; j < NUM_WRITE; j++) begin
            wr_ok[j] = bus.wr_en[j] && addr_ok(bus.wr_addr[j*AW +: AW]);
        end
    end

    // Ascending port order lets the highest-index port overwrite the others.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wr_ok[j] && (bus.wr_addr[j*AW +: AW] == AW'(r))) begin
                    regs_d[r] = bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .NUM_WRITE (NUM_WRITE),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .sb_set_en   (bus.sb_set_en),
        .sb_set_addr (bus.sb_set_addr),
        .sb_flush    (bus.sb_flush),
        .busy        (busy),
        .any_busy    (bus.any_busy)
    );

    // Read muxing: unmatched addresses (out of range, or register 0 when it
    // is hardwired) fall through to the zero defaults. Busy is never bypassed.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if ((bus.rd_addr[i*AW +: AW] == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                    rd_data_c[i*XLEN +: XLEN] = regs_q[r];
                    rd_busy_c[i]              = busy[r];
                end
            end
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wr_ok[j] && (bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])) begin
                        rd_data_c[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
        // Keep the bypass path from leaking write data while in reset.
        if (!rst_n) begin
            rd_data_c = '0;
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Two register files share one stimulus stream:
//   cfg0 : 32 registers, hardwired x0, bypass on,  two write ports
//   cfg1 : 24 registers, normal x0,    bypass off, two write ports
// Directed rows carry hand-computed expectations; every cycle is also
// compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    logic        sb_set_en;
    logic [4:0]  sb_addr;
    logic        sb_flush;

    int n_vec;
    int n_bad;

    regfile_mp_if #(.XLEN(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(2)) ifa ();
    regfile_mp_if #(.XLEN(32), .REG_COUNT(24), .NUM_READ(2), .NUM_WRITE(2)) ifb ();

    assign ifa.rd_addr     = {ra[1], ra[0]};
    assign ifa.wr_en       = wr_en;
    assign ifa.wr_addr     = {wa[1], wa[0]};
    assign ifa.wr_data     = {wd[1], wd[0]};
    assign ifa.sb_set_en   = sb_set_en;
    assign ifa.sb_set_addr = sb_addr;
    assign ifa.sb_flush    = sb_flush;
    assign ifb.rd_addr     = {ra[1], ra[0]};
    assign ifb.wr_en       = wr_en;
    assign ifb.wr_addr     = {wa[1], wa[0]};
    assign ifb.wr_data     = {wd[1], wd[0]};
    assign ifb.sb_set_en   = sb_set_en;
    assign ifb.sb_set_addr = sb_addr;
    assign ifb.sb_flush    = sb_flush;

    regfile_mp #(.XLEN(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(2),
                 .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_mp #(.XLEN(32), .REG_COUNT(24), .NUM_READ(2), .NUM_WRITE(2),
                 .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] mem [2][32];
    bit          mb  [2][32];

    function automatic int rcnt(int c); return (c == 0) ? 32 : 24; endfunction
    function automatic bit zr(int c);   return c == 0; endfunction
    function automatic bit bp(int c);   return c == 0; endfunction

    function automatic bit vld(int c, int a);
        return (a < rcnt(c)) && !(zr(c) && a == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int c, int i);
        int a;
        logic [31:0] v;
        a = int'(ra[i]);
        if (!rst_n || !vld(c, a)) return 32'd0;
        v = mem[c][a];
        if (bp(c))
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wa[j] == ra[i] && vld(c, int'(wa[j]))) v = wd[j];
        return v;
    endfunction

    function automatic logic exp_busy(int c, int i);
        return vld(c, int'(ra[i])) ? logic'(mb[c][ra[i]]) : 1'b0;
    endfunction

    function automatic logic exp_any(int c);
        logic o;
        o = 1'b0;
        for (int r = 0; r < 32; r++) o = o | mb[c][r];
        return o;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin
                mem[c][r] = 32'd0;
                mb[c][r]  = 1'b0;
            end
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < 2; j++)
                    if (wr_en[j] && vld(c, int'(wa[j]))) begin
                        mem[c][wa[j]] = wd[j];
                        mb[c][wa[j]]  = 1'b0;
                    end
                if (sb_set_en && vld(c, int'(sb_addr))) mb[c][sb_addr] = 1'b1;
                if (sb_flush)
                    for (int r = 0; r < 32; r++) mb[c][r] = 1'b0;
            end
        end
    endtask

    // ---------------- DUT access / checking ----------------
    function automatic logic [31:0] act_rd(int c, int i);
        return (c == 0) ? ifa.rd_data[i*32 +: 32] : ifb.rd_data[i*32 +: 32];
    endfunction
    function automatic logic act_busy(int c, int i);
        return (c == 0) ? ifa.rd_busy[i] : ifb.rd_busy[i];
    endfunction
    function automatic logic act_any(int c);
        return (c == 0) ? ifa.any_busy : ifb.any_busy;
    endfunction

    task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, c, $time, act, exp);
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_rd_data%0d", i), c, act_rd(c, i), exp_rd(c, i));
                chk($sformatf("model_rd_busy%0d", i), c, 32'(act_busy(c, i)), 32'(exp_busy(c, i)));
            end
            chk("model_any_busy", c, 32'(act_any(c)), 32'(exp_any(c)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        wr_en = 2'b00; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        sb_set_en = 1'b0; sb_addr = '0; sb_flush = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        se;
        logic [4:0]  sa;
        logic        fl;
        logic [31:0] a0, a1;
        logic [1:0]  abz;
        logic        aany;
        logic [31:0] b0, b1;
        logic [1:0]  bbz;
        logic        bany;
    } vec_t;

    vec_t tbl [18];

    initial begin
        n_vec = 0;
        n_bad = 0;
        //             we    wa0  wa1  wd0            wd1     ra0  ra1  se   sa    fl  | a0 a1 abz aany | b0 b1 bbz bany
        tbl[0]  = '{2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0};
        tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0,
                    32'hA5A5A5A5, 32'h0, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h0, 2'b00, 1'b0};
        tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0,
                    32'h22, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0, 32'hA5A5A5A5, 2'b00, 1'b0};
        tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0,
                    32'h22, 32'h22, 2'b00, 1'b0, 32'h22, 32'h22, 2'b00, 1'b0};
        tbl[4]  = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0,
                    32'h0, 32'h22, 2'b00, 1'b0, 32'h0, 32'h22, 2'b00, 1'b0};
        tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                    32'h0, 32'h0, 2'b00, 1'b0, 32'h1234, 32'h1234, 2'b00, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0,
                    32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h1234, 2'b00, 1'b0};
        tbl[7]  = '{2'b01, 5'd9, 5'd0, 32'h5, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                    32'h5, 32'h5, 2'b11, 1'b1, 32'h0, 32'h0, 2'b11, 1'b1};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                    32'h5, 32'h5, 2'b00, 1'b0, 32'h5, 32'h5, 2'b00, 1'b0};
        tbl[9]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h6, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0,
                    32'h6, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h5, 32'hA5A5A5A5, 2'b00, 1'b0};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0,
                    32'h6, 32'hA5A5A5A5, 2'b01, 1'b1, 32'h6, 32'hA5A5A5A5, 2'b01, 1'b1};
        tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd9, 1'b1, 5'd1, 1'b0,
                    32'h0, 32'h6, 2'b10, 1'b1, 32'h0, 32'h6, 2'b10, 1'b1};
        tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0,
                    32'h0, 32'h0, 2'b01, 1'b1, 32'h0, 32'h0, 2'b01, 1'b1};
        tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd2, 5'd3, 1'b1, 5'd3, 1'b0,
                    32'h0, 32'hA5A5A5A5, 2'b01, 1'b1, 32'h0, 32'hA5A5A5A5, 2'b01, 1'b1};
        tbl[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b1,
                    32'hA5A5A5A5, 32'h0, 2'b01, 1'b1, 32'hA5A5A5A5, 32'h0, 2'b01, 1'b1};
        tbl[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0,
                    32'hA5A5A5A5, 32'h0, 2'b00, 1'b0, 32'hA5A5A5A5, 32'h0, 2'b00, 1'b0};
        tbl[16] = '{2'b01, 5'd30, 5'd0, 32'hFF, 32'h0, 5'd30, 5'd30, 1'b1, 5'd30, 1'b0,
                    32'hFF, 32'hFF, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0};
        tbl[17] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd30, 5'd9, 1'b0, 5'd0, 1'b0,
                    32'hFF, 32'h6, 2'b01, 1'b1, 32'h0, 32'h6, 2'b00, 1'b0};

        // Reset state, with a write and a read to the same register pending.
        rst_n = 1'b0;
        idle();
        ra[0] = 5'd3; ra[1] = 5'd5;
        wr_en = 2'b01; wa[0] = 5'd3; wd[0] = 32'hCAFEF00D;
        model_reset();
        #2;
        for (int c = 0; c < 2; c++) begin
            chk("reset_rd_data0", c, act_rd(c, 0), 32'h0);
            chk("reset_rd_data1", c, act_rd(c, 1), 32'h0);
            chk("reset_any_busy", c, 32'(act_any(c)), 32'h0);
        end
        repeat (2) step();
        idle();
        rst_n = 1'b1;

        // Directed rows.
        for (int k = 0; k < 18; k++) begin
            wr_en = tbl[k].we; wa[0] = tbl[k].wa0; wa[1] = tbl[k].wa1;
            wd[0] = tbl[k].wd0; wd[1] = tbl[k].wd1;
            ra[0] = tbl[k].ra0; ra[1] = tbl[k].ra1;
            sb_set_en = tbl[k].se; sb_addr = tbl[k].sa; sb_flush = tbl[k].fl;
            @(negedge clk);
            chk($sformatf("row%0d_rd0", k), 0, act_rd(0, 0), tbl[k].a0);
            chk($sformatf("row%0d_rd1", k), 0, act_rd(0, 1), tbl[k].a1);
            chk($sformatf("row%0d_busy", k), 0, 32'(ifa.rd_busy), 32'(tbl[k].abz));
            chk($sformatf("row%0d_any", k), 0, 32'(ifa.any_busy), 32'(tbl[k].aany));
            chk($sformatf("row%0d_rd0", k), 1, act_rd(1, 0), tbl[k].b0);
            chk($sformatf("row%0d_rd1", k), 1, act_rd(1, 1), tbl[k].b1);
            chk($sformatf("row%0d_busy", k), 1, 32'(ifb.rd_busy), 32'(tbl[k].bbz));
            chk($sformatf("row%0d_any", k), 1, 32'(ifb.any_busy), 32'(tbl[k].bany));
            model_check();
            step();
        end

        // Mid-operation reset: x5 loaded, x6 marked busy, then reset arrives
        // while another write and set are pending.
        idle();
        wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_addr = 5'd6;
        ra[0] = 5'd5; ra[1] = 5'd6;
        step();
        wd[0] = 32'h77; sb_addr = 5'd7;
        #1;
        chk("pre_reset_rd_x5", 0, act_rd(0, 0), 32'h77);
        chk("pre_reset_rd_x5", 1, act_rd(1, 0), 32'hDEADBEEF);
        chk("pre_reset_busy_x6", 0, 32'(act_busy(0, 1)), 32'h1);
        chk("pre_reset_any", 1, 32'(act_any(1)), 32'h1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("in_reset_rd_x5", c, act_rd(c, 0), 32'h0);
            chk("in_reset_busy_x6", c, 32'(act_busy(c, 1)), 32'h0);
            chk("in_reset_any", c, 32'(act_any(c)), 32'h0);
        end
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            chk("post_reset_rd_x5", c, act_rd(c, 0), 32'h0);
            chk("post_reset_busy_x6", c, 32'(act_busy(c, 1)), 32'h0);
            chk("post_reset_any", c, 32'(act_any(c)), 32'h0);
        end
        model_check();
        step();

        // Randomised traffic against the model; a narrow address window
        // makes collisions and bypass hits frequent.
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 2; j++) begin
                wr_en[j] = ($urandom_range(0, 2) != 0);
                wa[j]    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                wd[j]    = $urandom;
                ra[j]    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            sb_set_en = ($urandom_range(0, 1) != 0);
            sb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            sb_flush  = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            model_check();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, two-read core register file.
- Configurable width, depth, read-port count and write-port count. Optional hardwired-zero register 0. Optional same-cycle write-to-read bypass.
- Integrated busy scoreboard for the issue stage. Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width in bits.
- REG_COUNT, 32, number of architectural registers (>= 2).
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and scoreboard sets.
- BYPASS, 1, 1 = a read returns the data being written to the same address in the same cycle.
- AW, $clog2(REG_COUNT), derived address width; not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_READ*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_READ*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_READ  scoreboard busy bit for each read address.
- wr_en  in  NUM_WRITE  write enables.
- wr_addr  in  NUM_WRITE*AW  write addresses.
- wr_data  in  NUM_WRITE*XLEN  write data.
- sb_set_en  in  1  mark register sb_set_addr as pending (an instruction issued).
- sb_set_addr  in  AW  destination address to mark.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset
  - rst_n low asynchronously clears all REG_COUNT registers to 0 and all busy bits to 0.
  - During and after reset: rd_data = 0, rd_busy = 0, any_busy = 0.
  - Reset in mid-operation discards any in-flight write or set.
- Reads
  - Combinational, zero latency, from the current array state.
  - An address >= REG_COUNT (non-power-of-2 depth) reads 0 with busy 0.
  - ZERO_REG=1: address 0 always reads 0 with busy 0.
- Writes
  - At posedge, for each port j with wr_en[j]=1 and a valid address, the register is loaded with wr_data[j].
  - Ignored: addresses >= REG_COUNT, and address 0 when ZERO_REG=1.
  - Collision (both ports to the same address): the higher-index port wins, data and bypass alike.
- Bypass (BYPASS=1)
  - If a read address matches an active, valid write address in the same cycle, rd_data returns the winning write data.
  - Bypass never applies to register 0 when ZERO_REG=1.
  - BYPASS=0: a read in the same cycle as the write returns the old value; the new value is visible the next cycle.
- Scoreboard
  - Per-register busy bit, updated at posedge.
  - Set when sb_set_en=1 and the address is valid and non-zero (non-zero applies when ZERO_REG=1).
  - Cleared by any valid wr_en to that address.
  - Same cycle, same address, set and clear together: the set wins, because a new producer is issued.
  - sb_flush=1 clears all bits and overrides a same-cycle set.
  - Writes still update data during a flush.
  - rd_busy reflects registered state only; a same-cycle clear or set is not bypassed into it.
- Width rules
  - No arithmetic.
  - Address comparisons are done at full AW width.
  - Index decode is guarded against out-of-range addresses, so there is no array overrun in simulation.

Decomposition:
- Shared package regfile_pkg:
  - XLEN_DEFAULT, REG_COUNT_DEFAULT.
  - typedef reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]) for the default core.
- Sub-module regfile_scoreboard:
  - Holds the REG_COUNT busy vector with the set/clear/flush priority logic.
  - Parameters: REG_COUNT, NUM_WRITE, ZERO_REG.
  - Outputs: the busy vector and any_busy.
- The data array, bypass logic and read muxing stay in regfile_mp.

Test Plan:
1. Reset and x0
   - Stimulus: assert rst_n=0 mid-sequence after writing x5=0xDEADBEEF; deassert; then write x0=0x1234 with ZERO_REG=1.
   - Required: rd_data for x5 = 0 immediately on reset; x0 reads 0; any_busy = 0.
2. Dual-write collision
   - Stimulus: NUM_WRITE=2; port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle.
   - Required: a bypassed read shows 0x22 that cycle; the next cycle reads 0x22.
3. Bypass off versus on
   - Stimulus: write x3=0xA5A5A5A5 while reading x3, with old value 0.
   - Required: BYPASS=1 returns 0xA5A5A5A5 that cycle; BYPASS=0 returns 0, then 0xA5A5A5A5 the next cycle.
4. Scoreboard
   - Stimulus: set x9; next cycle write x9=0x5.
   - Required: rd_busy=1 for one cycle, then 0.
   - Stimulus: set and write x9 in the same cycle.
   - Required: busy=1 afterwards.
5. Flush
   - Stimulus: set x1, x2, x3 over three cycles; assert sb_flush together with sb_set_en on x4.
   - Required: all busy bits 0 and any_busy=0 the next cycle.
6. Non-power-of-2 depth
   - Stimulus: REG_COUNT=24; write address 30 with 0xFF; read address 30.
   - Required: no state change, read 0, busy 0.
